// File: rtl/live_ratio_report_pkg.sv
// Shared types and constants for the live-ratio spill reporter.
package lr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SNAP,
        DIV,
        PUSH
    } lr_state_e;

    localparam logic [3:0] LIVE_FALL_PAT = 4'b1100;
    localparam logic [3:0] LIVE_RISE_PAT = 4'b0011;

    localparam int SPILL_W = 16;
    localparam int FLAG_W  = 2;
    localparam int LIVE_W  = 32;
    localparam int DROP_W  = 8;

    localparam int FLAG_NZERO = 0;
    localparam int FLAG_SAT   = 1;

    // Fixed-width fields sit at the bottom of a record; count/ratio fields follow.
    localparam int REC_SPILL_OFS = 0;
    localparam int REC_FLAGS_OFS = REC_SPILL_OFS + SPILL_W;
    localparam int REC_CNT_OFS   = REC_FLAGS_OFS + FLAG_W;

endpackage

// File: rtl/live_ratio_report_div.sv
// Restoring divider: quot = (num << FRAC_W) / den, fixed CNT_W+FRAC_W iterations.
// Latency: done high in the last iteration cycle; quot/div_zero valid from the next cycle.
// No backpressure: start is only issued by the owner FSM while the divider is idle.
module lr_div_serial #(
    parameter int CNT_W  = 32,
    parameter int FRAC_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CNT_W-1:0]          num,
    input  logic [CNT_W-1:0]          den,
    output logic                      done,
    output logic [CNT_W+FRAC_W-1:0]   quot,
    output logic                      div_zero
);
    localparam int N  = CNT_W + FRAC_W;
    localparam int CW = $clog2(N);

    logic             run_q, run_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N-1:0]     num_q, num_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] den_q, den_d;
    logic             dz_q, dz_d;

    logic [CNT_W:0]   rem_sh;
    logic             ge;

    always_comb begin
        run_d  = run_q;
        cnt_d  = cnt_q;
        num_d  = num_q;
        rem_d  = rem_q;
        den_d  = den_q;
        dz_d   = dz_q;
        rem_sh = {rem_q, num_q[N-1]};
        ge     = rem_sh >= {1'b0, den_q};
        if (start) begin
            run_d = 1'b1;
            cnt_d = '0;
            num_d = {num, {FRAC_W{1'b0}}};
            rem_d = '0;
            den_d = den;
            dz_d  = (den == '0);
        end else if (run_q) begin
            // Dividend bits shift out the top while quotient bits fill in from the bottom.
            num_d = {num_q[N-2:0], ge};
            rem_d = ge ? (rem_sh[CNT_W-1:0] - den_q) : rem_sh[CNT_W-1:0];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            num_q <= '0;
            rem_q <= '0;
            den_q <= '0;
            dz_q  <= 1'b0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            num_q <= num_d;
            rem_q <= rem_d;
            den_q <= den_d;
            dz_q  <= dz_d;
        end
    end

    assign done     = run_q && (cnt_q == CW'(N - 1));
    assign quot     = num_q;
    assign div_zero = dz_q;

endmodule

// File: rtl/live_ratio_report.sv
// Per-spill n_out/n_in ratio reporter with show-ahead record FIFO (LIVE_RATIO_LIVETIME_EN adds rec_live).
// Latency: fall detected at edge T -> record written at T+CNT_W+FRAC_W+2.
// Backpressure: none upstream; falls while busy or pushes into a full FIFO are dropped and counted.
module live_ratio_report
    import lr_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int FRAC_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 live,
    input  logic [CNT_W-1:0]     n_in,
    input  logic [CNT_W-1:0]     n_out,
    input  logic                 rd_en,
    output logic                 rec_valid,
    output logic [SPILL_W-1:0]   rec_spill,
    output logic [CNT_W-1:0]     rec_n_in,
    output logic [CNT_W-1:0]     rec_n_out,
    output logic [FRAC_W:0]      rec_ratio,
`ifdef LIVE_RATIO_LIVETIME_EN
    output logic [LIVE_W-1:0]    rec_live,
`endif
    output logic [FLAG_W-1:0]    rec_flags,
    output logic                 busy,
    output logic [DROP_W-1:0]    drop_cnt
);
    localparam int RAT_W    = FRAC_W + 1;
    localparam int N        = CNT_W + FRAC_W;
    localparam int PW       = $clog2(FIFO_DEPTH);
    localparam int OFS_NIN  = REC_CNT_OFS;
    localparam int OFS_NOUT = OFS_NIN + CNT_W;
    localparam int OFS_RAT  = OFS_NOUT + CNT_W;
    localparam int OFS_LIVE = OFS_RAT + RAT_W;
`ifdef LIVE_RATIO_LIVETIME_EN
    localparam int REC_W    = OFS_LIVE + LIVE_W;
`else
    localparam int REC_W    = OFS_LIVE;
`endif

    lr_state_e          state_q, state_d;
    logic [3:0]         hist_q, hist_d;
    logic [SPILL_W-1:0] spill_q, spill_d, snap_spill_q, snap_spill_d;
    logic [CNT_W-1:0]   snap_nin_q, snap_nin_d, snap_nout_q, snap_nout_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]        cnt_q, cnt_d;
    logic [REC_W-1:0]   mem_q [FIFO_DEPTH];

    logic               fall, div_start, div_done, div_zero, sat, do_push, do_pop;
    logic [N-1:0]       quot;
    logic [RAT_W-1:0]   ratio;
    logic [FLAG_W-1:0]  flags;
    logic [REC_W-1:0]   rec_wr, head;
    logic [DROP_W:0]    drop_sum;

    assign fall = (hist_q == LIVE_FALL_PAT);

    always_comb begin
        state_d      = state_q;
        hist_d       = {hist_q[2:0], live};
        spill_d      = spill_q;
        snap_spill_d = snap_spill_q;
        snap_nin_d   = snap_nin_q;
        snap_nout_d  = snap_nout_q;
        div_start    = 1'b0;
        if (fall) begin
            spill_d = spill_q + SPILL_W'(1);
        end
        case (state_q)
            IDLE: if (fall) begin
                state_d      = SNAP;
                snap_spill_d = spill_q;
                snap_nin_d   = n_in;
                snap_nout_d  = n_out;
            end
            SNAP: begin
                div_start = 1'b1;
                state_d   = DIV;
            end
            DIV:  if (div_done) state_d = PUSH;
            PUSH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    lr_div_serial #(.CNT_W(CNT_W), .FRAC_W(FRAC_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .num      (snap_nout_q),
        .den      (snap_nin_q),
        .done     (div_done),
        .quot     (quot),
        .div_zero (div_zero)
    );

    assign sat   = |quot[N-1:RAT_W];
    assign ratio = (div_zero || sat) ? '1 : quot[RAT_W-1:0];
    always_comb begin
        flags             = '0;
        flags[FLAG_NZERO] = div_zero;
        flags[FLAG_SAT]   = div_zero || sat;
    end

`ifdef LIVE_RATIO_LIVETIME_EN
    logic [LIVE_W-1:0] live_cnt_q, live_cnt_d, snap_live_q, snap_live_d;

    // Counts the history tap two cycles behind live, so a run that starts with
    // the rise pattern and ends with the fall pattern is counted exactly once.
    always_comb begin
        live_cnt_d  = live_cnt_q;
        snap_live_d = snap_live_q;
        if (hist_q == LIVE_RISE_PAT) begin
            live_cnt_d = LIVE_W'(1);
        end else if (hist_q[1] && (live_cnt_q != '1)) begin
            live_cnt_d = live_cnt_q + LIVE_W'(1);
        end
        if (fall && (state_q == IDLE)) begin
            snap_live_d = live_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_cnt_q  <= '0;
            snap_live_q <= '0;
        end else begin
            live_cnt_q  <= live_cnt_d;
            snap_live_q <= snap_live_d;
        end
    end

    assign rec_wr = {snap_live_q, ratio, snap_nout_q, snap_nin_q, flags, snap_spill_q};
`else
    assign rec_wr = {ratio, snap_nout_q, snap_nin_q, flags, snap_spill_q};
`endif

    always_comb begin
        do_pop   = rd_en && (cnt_q != '0);
        // A full FIFO still accepts the record when the head is popped in the same cycle.
        do_push  = (state_q == PUSH) && ((cnt_q != (PW+1)'(FIFO_DEPTH)) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        drop_sum = {1'b0, drop_q}
                 + (DROP_W+1)'(fall && (state_q != IDLE))
                 + (DROP_W+1)'((state_q == PUSH) && !do_push);
        drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hist_q       <= '0;
            spill_q      <= '0;
            snap_spill_q <= '0;
            snap_nin_q   <= '0;
            snap_nout_q  <= '0;
            drop_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            hist_q       <= hist_d;
            spill_q      <= spill_d;
            snap_spill_q <= snap_spill_d;
            snap_nin_q   <= snap_nin_d;
            snap_nout_q  <= snap_nout_d;
            drop_q       <= drop_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= rec_wr;
        end
    end

    assign rec_valid = (cnt_q != '0);
    assign head      = rec_valid ? mem_q[rd_ptr_q] : '0;
    assign rec_spill = head[REC_SPILL_OFS +: SPILL_W];
    assign rec_flags = head[REC_FLAGS_OFS +: FLAG_W];
    assign rec_n_in  = head[OFS_NIN +: CNT_W];
    assign rec_n_out = head[OFS_NOUT +: CNT_W];
    assign rec_ratio = head[OFS_RAT +: RAT_W];
`ifdef LIVE_RATIO_LIVETIME_EN
    assign rec_live  = head[OFS_LIVE +: LIVE_W];
`endif
    assign busy      = (state_q != IDLE);
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_live_ratio_report.sv
// Scoreboard bench for live_ratio_report: expected records queued per spill, compared on readout.
module tb_live_ratio_report;

    typedef struct {
        logic [15:0] spill;
        logic [31:0] ni;
        logic [31:0] no;
        logic [16:0] ratio;
        logic [1:0]  flags;
        logic [31:0] live;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst, live, rd_en;
    logic [31:0] n_in, n_out;
    logic        rec_valid, busy;
    logic [15:0] rec_spill;
    logic [31:0] rec_n_in, rec_n_out;
    logic [16:0] rec_ratio;
    logic [1:0]  rec_flags;
    logic [7:0]  drop_cnt;
`ifdef LIVE_RATIO_LIVETIME_EN
    logic [31:0] rec_live;
`endif

    always #5 clk = ~clk;

    live_ratio_report dut (
        .clk       (clk),
        .rst       (rst),
        .live      (live),
        .n_in      (n_in),
        .n_out     (n_out),
        .rd_en     (rd_en),
        .rec_valid (rec_valid),
        .rec_spill (rec_spill),
        .rec_n_in  (rec_n_in),
        .rec_n_out (rec_n_out),
        .rec_ratio (rec_ratio),
`ifdef LIVE_RATIO_LIVETIME_EN
        .rec_live  (rec_live),
`endif
        .rec_flags (rec_flags),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    rec_t        sb[$];
    logic [15:0] spill_exp;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic rec_t model(input logic [15:0] sp, input logic [31:0] ni,
                                   input logic [31:0] no, input int hi);
        rec_t        r;
        logic [63:0] q;
        r.spill = sp;
        r.ni    = ni;
        r.no    = no;
        r.live  = hi;
        if (ni == 0) begin
            r.ratio = 17'h1FFFF;
            r.flags = 2'b11;
        end else begin
            q = {16'h0, no, 16'h0} / {32'h0, ni};
            if (q >= 64'h20000) begin
                r.ratio = 17'h1FFFF;
                r.flags = 2'b10;
            end else begin
                r.ratio = q[16:0];
                r.flags = 2'b00;
            end
        end
        return r;
    endfunction

    task automatic do_reset();
        rst   = 1'b1;
        live  = 1'b0;
        rd_en = 1'b0;
        repeat (3) tick();
        rst       = 1'b0;
        spill_exp = '0;
        sb.delete();
        repeat (2) tick();
    endtask

    // Live high for hi cycles then low; keep=0 means the record is expected to be lost.
    task automatic spill(input logic [31:0] ni, input logic [31:0] no, input int hi, input bit keep);
        n_in  = ni;
        n_out = no;
        live  = 1'b1;
        repeat (hi) tick();
        live = 1'b0;
        if (keep) sb.push_back(model(spill_exp, ni, no, hi));
        spill_exp = spill_exp + 16'd1;
    endtask

    task automatic drain(input int n);
        rec_t e;
        int   w;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (!rec_valid && w < 200) begin
                tick();
                w++;
            end
            chk("rec_valid", rec_valid, 1);
            chk("sb_depth", (sb.size() > 0), 1);
            if (rec_valid && sb.size() > 0) begin
                e = sb.pop_front();
                chk("spill", rec_spill, e.spill);
                chk("n_in", rec_n_in, e.ni);
                chk("n_out", rec_n_out, e.no);
                chk("ratio", rec_ratio, e.ratio);
                chk("flags", rec_flags, e.flags);
`ifdef LIVE_RATIO_LIVETIME_EN
                chk("live", rec_live, e.live);
`endif
                rd_en = 1'b1;
                tick();
                rd_en = 1'b0;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          cyc;
        logic [31:0] ni_tab [6];
        logic [31:0] no_tab [6];
        logic [31:0] rn;

        n_in  = '0;
        n_out = '0;
        do_reset();
        chk("rst_valid", rec_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_spill", rec_spill, 0);
        chk("rst_ratio", rec_ratio, 0);
        chk("rst_flags", rec_flags, 0);

        // Basic ratio and latency: 2 cycles of history, 50 cycles of processing, 1 to observe.
        spill(1000, 500, 6, 1);
        cyc = 0;
        while (!rec_valid && cyc < 200) begin
            tick();
            cyc++;
            if (cyc == 10) chk("busy_mid", busy, 1);
        end
        chk("latency", cyc, 53);
        drain(1);
        chk("idle_after", busy, 0);

        // Ratio corner cases plus a few random pairs, read back one at a time.
        ni_tab = '{32'd0, 32'd1, 32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'd5};
        no_tab = '{32'd7, 32'd3, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        for (int i = 0; i < 6; i++) begin
            spill(ni_tab[i], no_tab[i], 5, 1);
            repeat (55) tick();
            drain(1);
        end
        for (int i = 0; i < 4; i++) begin
            rn = $urandom_range(100000, 1);
            spill(rn, $urandom_range(3 * rn, 0), 4 + i, 1);
            repeat (55) tick();
            drain(1);
        end

        // Nine spills without reads: the ninth finds the FIFO full.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            spill(32'd100 + k, 32'd40 + k, 3, (k < 8));
            repeat (55) tick();
        end
        chk("full_drop", drop_cnt, 1);
        drain(8);
        chk("empty_after_8", rec_valid, 0);

        // Second fall while the first is still dividing.
        do_reset();
        spill(200, 100, 6, 1);
        repeat (16) tick();
        chk("busy_before_2nd", busy, 1);
        spill(200, 100, 2, 0);
        repeat (60) tick();
        chk("busy_drop", drop_cnt, 1);
        spill(300, 600, 7, 1);
        repeat (55) tick();
        drain(2);

        // Reset mid-divide with a record already queued and a nonzero drop count.
        spill(10, 9, 4, 0);
        repeat (55) tick();
        chk("queued_pre_rst", rec_valid, 1);
        spill(10, 9, 4, 0);
        repeat (25) tick();
        chk("busy_pre_rst", busy, 1);
        do_reset();
        chk("rst2_valid", rec_valid, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_drop", drop_cnt, 0);
        chk("rst2_ratio", rec_ratio, 0);
        repeat (60) tick();
        chk("no_late_push", rec_valid, 0);
        spill(4000, 1000, 5, 1);
        repeat (55) tick();
        drain(1);

        // One-cycle live glitch: no fall pattern, so no record and no spill increment.
        live = 1'b1;
        tick();
        live = 1'b0;
        repeat (60) tick();
        chk("glitch_valid", rec_valid, 0);
        chk("glitch_busy", busy, 0);
`ifdef LIVE_RATIO_LIVETIME_EN
        spill(777, 333, 12345, 1);
`else
        spill(777, 333, 9, 1);
`endif
        repeat (55) tick();
        drain(1);
        chk("final_empty", rec_valid, 0);
        chk("final_drop", drop_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
